// File: rtl/led_scan_controller_if.sv
// Bus between the scan controller and its user.
// The user side drives the display word and enable.
// The controller side returns the scan position and the digit drive.
interface led_scan_controller_if #(
    parameter int NUM_DIGITS = 8
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    en;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    busy;
    logic [3:0]              char;
    logic [NUM_DIGITS-1:0]   AN;
    logic [IW-1:0]           digit_idx;
    logic                    frame_tick;

    modport master (
        output en, load, value, blank,
        input  busy, char, AN, digit_idx, frame_tick
    );

    modport slave (
        input  en, load, value, blank,
        output busy, char, AN, digit_idx, frame_tick
    );
endinterface

// File: rtl/led_scan_controller.sv
// Time-multiplexed seven-segment scanner.
// A new word is held in a pending buffer and becomes active only when the
// digit index wraps, so a frame never mixes two words. char and AN are
// registered from next-state values, so they move on the same edge as
// digit_idx.
module led_scan_controller #(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    led_scan_controller_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int VW = 4 * NUM_DIGITS;

    logic [CW-1:0]         cnt, ncnt;
    logic [IW-1:0]         idx, nidx;
    logic [VW-1:0]         pend_value, act_value, nact_value;
    logic [NUM_DIGITS-1:0] pend_blank, act_blank, nact_blank;
    logic [NUM_DIGITS-1:0] nan, an_q;
    logic                  busy, nbusy, wrap, commit;
    logic [3:0]            char_q;
    logic                  tick_q;

    // Next scan position, commit decision and next anode pattern
    always_comb begin
        ncnt       = cnt;
        nidx       = idx;
        wrap       = 1'b0;
        commit     = 1'b0;
        nact_value = act_value;
        nact_blank = act_blank;
        nbusy      = busy;
        nan        = '1;

        if (bus.en) begin
            if (cnt == CW'(PRESCALE - 1)) begin
                ncnt = '0;
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    nidx = '0;
                    wrap = 1'b1;
                end else begin
                    nidx = idx + IW'(1);
                end
            end else begin
                ncnt = cnt + CW'(1);
            end
            commit = wrap && (busy || bus.load);
        end else begin
            // Nothing is lit while disabled, so tearing is impossible:
            // commit at once.
            commit = busy || bus.load;
        end

        // A load on the commit edge bypasses the older pending word
        if (commit) begin
            nact_value = bus.load ? bus.value : pend_value;
            nact_blank = bus.load ? bus.blank : pend_blank;
            nbusy      = 1'b0;
        end else if (bus.load) begin
            nbusy = 1'b1;
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
            nan[i] = !(bus.en && (IW'(i) == nidx) && !nact_blank[i]);
        end
    end

    // State and registered display outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            pend_value <= '0;
            pend_blank <= '1;
            act_value  <= '0;
            act_blank  <= '1;
            busy       <= 1'b0;
            char_q     <= '0;
            an_q       <= '1;
            tick_q     <= 1'b0;
        end else begin
            cnt       <= ncnt;
            idx       <= nidx;
            act_value <= nact_value;
            act_blank <= nact_blank;
            busy      <= nbusy;
            char_q    <= nact_value[{nidx, 2'b00} +: 4];
            an_q      <= nan;
            tick_q    <= wrap;
            if (bus.load) begin
                pend_value <= bus.value;
                pend_blank <= bus.blank;
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.char       = char_q;
    assign bus.AN         = an_q;
    assign bus.digit_idx  = idx;
    assign bus.frame_tick = tick_q;
endmodule
